// File: rtl/mm_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mm_host_sequencer : streams operands into data memory, starts  |
// | core 1, waits for END and streams the result region back out.  |
// | Revision 1.0                                                    |
// +----------------------------------------------------------------+
module mm_host_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              go,
  input  logic [ADDR_W-1:0] cfg_load_base,
  input  logic [15:0]       cfg_load_len,
  input  logic [ADDR_W-1:0] cfg_res_base,
  input  logic [15:0]       cfg_res_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] current_addr,
  output logic              write_from_tb,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        addr_mux_select,
  output logic [ADDR_W-1:0] ar_in,
  input  logic [DATA_W-1:0] dmem_rd_data,
  output logic              START,
  input  logic              END,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // The wait counter only has to reach TIMEOUT-1 before it leaves RUN_WAIT.
  localparam int                 c_cnt_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [2:0]         c_lat_last = 3'(RD_LAT - 1);
  localparam logic [1:0]         c_mux_core = 2'b00;
  localparam logic [1:0]         c_mux_wr   = 2'b01;
  localparam logic [1:0]         c_mux_rd   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RUN_PULSE  = 3'd2,
    ST_RUN_WAIT   = 3'd3,
    ST_READ_ISSUE = 3'd4,
    ST_READ_WAIT  = 3'd5,
    ST_READ_HOLD  = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_load_base;
  logic [15:0]         r_load_len;
  logic [ADDR_W-1:0]   r_res_base;
  logic [15:0]         r_res_len;
  logic [15:0]         r_k;
  logic [15:0]         r_r;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [2:0]          r_lat;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_error;
  logic                r_end_s;
  logic                r_end_p;
  logic                w_end_rise;
  logic                w_capture;
  logic [ADDR_W-1:0]   w_rd_addr;

  assign w_end_rise = r_end_s & ~r_end_p;
  // ISSUE counts as the first latency cycle, so a word costs RD_LAT+1 cycles.
  assign w_capture  = ((r_state == ST_READ_ISSUE) || (r_state == ST_READ_WAIT)) &&
                      (r_lat == c_lat_last);
  assign w_rd_addr  = r_res_base + ADDR_W'(r_r);
  assign busy       = (r_state != ST_IDLE);
  assign out_data   = r_out_data;
  assign error      = r_error;

  always_comb begin
    w_state_nxt     = r_state;
    in_ready        = 1'b0;
    write_from_tb   = 1'b0;
    current_addr    = '0;
    mem_data        = '0;
    addr_mux_select = c_mux_core;
    ar_in           = '0;
    START           = 1'b0;
    out_valid       = 1'b0;
    done            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) w_state_nxt = (cfg_load_len == 16'd0) ? ST_RUN_PULSE : ST_LOAD;
      end
      ST_LOAD: begin
        addr_mux_select = c_mux_wr;
        in_ready        = 1'b1;
        if (in_valid) begin
          write_from_tb = 1'b1;
          mem_data      = in_data;
          current_addr  = r_load_base + ADDR_W'(r_k);
          if (r_k == r_load_len - 16'd1) w_state_nxt = ST_RUN_PULSE;
        end
      end
      ST_RUN_PULSE: begin
        START       = 1'b1;
        w_state_nxt = ST_RUN_WAIT;
      end
      ST_RUN_WAIT: begin
        if (w_end_rise)
          w_state_nxt = (r_res_len == 16'd0) ? ST_DONE : ST_READ_ISSUE;
        else if (r_cnt == c_cnt_last)
          w_state_nxt = ST_DONE;
      end
      ST_READ_ISSUE: begin
        addr_mux_select = c_mux_rd;
        ar_in           = w_rd_addr;
        w_state_nxt     = w_capture ? ST_READ_HOLD : ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        addr_mux_select = c_mux_rd;
        ar_in           = w_rd_addr;
        if (w_capture) w_state_nxt = ST_READ_HOLD;
      end
      ST_READ_HOLD: begin
        addr_mux_select = c_mux_rd;
        ar_in           = w_rd_addr;
        out_valid       = 1'b1;
        if (out_ready)
          w_state_nxt = (r_r == r_res_len - 16'd1) ? ST_DONE : ST_READ_ISSUE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_load_base <= '0;
      r_load_len  <= '0;
      r_res_base  <= '0;
      r_res_len   <= '0;
      r_k         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_out_data  <= '0;
      r_error     <= 1'b0;
      r_end_s     <= 1'b0;
      r_end_p     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_end_s <= END;
      r_end_p <= r_end_s;
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_load_base <= cfg_load_base;
            r_load_len  <= cfg_load_len;
            r_res_base  <= cfg_res_base;
            r_res_len   <= cfg_res_len;
            r_k         <= '0;
            r_r         <= '0;
            r_error     <= 1'b0;
          end
        end
        ST_LOAD:      if (in_valid) r_k <= r_k + 16'd1;
        ST_RUN_PULSE: r_cnt <= '0;
        ST_RUN_WAIT: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (!w_end_rise && (r_cnt == c_cnt_last)) r_error <= 1'b1;
        end
        ST_READ_ISSUE, ST_READ_WAIT: begin
          if (w_capture) begin
            r_out_data <= dmem_rd_data;
            r_lat      <= '0;
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        ST_READ_HOLD: if (out_ready) r_r <= r_r + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_host_sequencer.sv
`default_nettype none
// Scoreboard bench for mm_host_sequencer: directed jobs push expected writes/reads,
// a negedge monitor pops and compares whenever the DUT writes or hands off a result.
module tb_mm_host_sequencer;
  localparam int TMO = 16;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        go = 1'b0;
  logic [15:0] cfg_load_base = '0, cfg_load_len = '0, cfg_res_base = '0, cfg_res_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [15:0] current_addr, mem_data, ar_in, out_data;
  logic        write_from_tb, START, out_valid, busy, done, error;
  logic [1:0]  addr_mux_select;
  logic [15:0] dmem_rd_data;
  logic        END = 1'b0;
  logic        out_ready = 1'b1;

  mm_host_sequencer #(.DATA_W(16), .ADDR_W(16), .RD_LAT(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .RESET(RESET), .go(go),
    .cfg_load_base(cfg_load_base), .cfg_load_len(cfg_load_len),
    .cfg_res_base(cfg_res_base), .cfg_res_len(cfg_res_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .current_addr(current_addr), .write_from_tb(write_from_tb), .mem_data(mem_data),
    .addr_mux_select(addr_mux_select), .ar_in(ar_in), .dmem_rd_data(dmem_rd_data),
    .START(START), .END(END), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .error(error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Data memory model: write via the loader port, read with LAT cycles of latency.
  logic [15:0] mem [256];
  logic [15:0] rd_q;
  logic        tb_we = 1'b0;
  logic [7:0]  tb_wa = '0;
  logic [15:0] tb_wd = '0;
  assign dmem_rd_data = rd_q;
  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (write_from_tb && addr_mux_select == 2'b01) mem[current_addr[7:0]] <= mem_data;
    rd_q <= (addr_mux_select == 2'b10) ? mem[ar_in[7:0]] : 16'hDEAD;
  end

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  int          wr_cyc[$];
  int checks = 0, errors = 0;
  int start_cnt = 0, done_cnt = 0, last_start_cyc = 0, last_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: scoreboard pops plus protocol checks, sampled mid-cycle.
  initial begin
    logic p_ov, p_or, p_st;
    logic [15:0] p_od;
    wr_t e;
    p_ov = 0; p_or = 0; p_st = 0; p_od = '0;
    forever begin
      @(negedge clk);
      if (!RESET) begin
        p_ov = 0; p_or = 0; p_st = 0;
      end else begin
        if (write_from_tb) begin
          check("wr_mux", addr_mux_select, 2'b01);
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", current_addr, e.addr);
            check("wr_data", mem_data, e.data);
          end
          wr_cyc.push_back(cyc);
        end
        if (p_ov && !p_or) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, p_od);
        end
        if (out_valid && out_ready) begin
          check("rd_mux", addr_mux_select, 2'b10);
          check("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) check("rd_data", out_data, exp_rd.pop_front());
        end
        if (START) begin
          check("start_width", p_st, 0);
          check("start_mux", addr_mux_select, 2'b00);
          start_cnt++;
          last_start_cyc = cyc;
        end
        if (done) begin done_cnt++; last_done_cyc = cyc; end
        p_ov = out_valid; p_or = out_ready; p_od = out_data; p_st = START;
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return START;
      1:       return done;
      default: return out_valid;
    endcase
  endfunction

  task automatic wait_for(input int w, input int bound, input string name);
    int n = 0;
    @(negedge clk);
    while (!sig(w) && n < bound) begin n++; @(negedge clk); end
    check(name, sig(w), 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int go_cyc = 0;
  task automatic start_job(input logic [15:0] lb, ll, rb, rl);
    cfg_load_base = lb; cfg_load_len = ll; cfg_res_base = rb; cfg_res_len = rl;
    go = 1'b1; go_cyc = cyc;
    tick(1);
    go = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] aa, input logic [15:0] dd);
    int n = 0;
    exp_wr.push_back('{addr: aa, data: dd});
    in_valid = 1'b1; in_data = dd;
    @(negedge clk);
    while (!in_ready && n < 40) begin n++; @(negedge clk); end
    check("in_ready_wait", in_ready, 1);
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    int d0, s0;
    // Reset state and memory preload
    tick(2);
    check("reset_ctrl", {busy, in_ready, START, done, error, out_valid, write_from_tb, addr_mux_select}, 0);
    check("reset_bus", {current_addr, ar_in}, 0);
    tb_we = 1; tb_wa = 8'h20; tb_wd = 16'h0011; tick(1);
    tb_wa = 8'h21; tb_wd = 16'h0022; tick(1);
    tb_we = 0; RESET = 1'b1; tick(2);
    check("idle_busy", busy, 0);

    // 1: back-to-back load then START
    wr_cyc.delete(); s0 = start_cnt;
    start_job(16'h0000, 16'd4, 16'h0020, 16'd2);
    exp_rd.push_back(16'h0011); exp_rd.push_back(16'h0022);
    push_word(16'h0000, 16'h0005); push_word(16'h0001, 16'h0006);
    push_word(16'h0002, 16'h0007); push_word(16'h0003, 16'h0008);
    check("in_ready_after_load", in_ready, 0);
    wait_for(0, 10, "start_seen");
    tick(1);
    check("wr_count", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      check("load_b2b", wr_cyc[3] - wr_cyc[0], 3);
      check("start_after_load", last_start_cyc, wr_cyc[3] + 1);
    end
    check("start_count", start_cnt, s0 + 1);
    check("mem_0", mem[8'h00], 16'h0005);
    check("mem_3", mem[8'h03], 16'h0008);

    // 2: readback after END
    d0 = done_cnt;
    tick(9); END = 1'b1;
    wait_for(1, 60, "done_seen_t2");
    tick(1);
    check("busy_after_done", busy, 0);
    check("done_pulses_t2", done_cnt, d0 + 1);
    check("reads_drained_t2", exp_rd.size(), 0);
    END = 1'b0;

    // 3: input gap and output stall
    out_ready = 1'b0;
    start_job(16'h0040, 16'd4, 16'h0020, 16'd2);
    exp_rd.push_back(16'h0011); exp_rd.push_back(16'h0022);
    push_word(16'h0040, 16'h00A1); push_word(16'h0041, 16'h00A2);
    tick(3);
    push_word(16'h0042, 16'h00A3); push_word(16'h0043, 16'h00A4);
    wait_for(0, 10, "start_seen_t3");
    tick(4); END = 1'b1;
    wait_for(2, 40, "valid_seen_t3");
    tick(5);
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 16'h0011);
    out_ready = 1'b1;
    wait_for(1, 60, "done_seen_t3");
    tick(1);
    check("reads_drained_t3", exp_rd.size(), 0);
    check("mem_41", mem[8'h41], 16'h00A2);
    check("mem_43", mem[8'h43], 16'h00A4);
    END = 1'b0;

    // 4: zero lengths with END already high
    END = 1'b1; tick(3);
    d0 = done_cnt;
    start_job(16'h0000, 16'd0, 16'h0020, 16'd0);
    wait_for(0, 5, "start_seen_t4");
    tick(1);
    check("start_after_go", last_start_cyc, go_cyc + 1);
    tick(5);
    check("stale_end_busy", busy, 1);
    check("stale_end_no_done", done_cnt, d0);
    END = 1'b0; tick(3); END = 1'b1;
    wait_for(1, 20, "done_seen_t4");
    tick(1);
    check("done_pulses_t4", done_cnt, d0 + 1);
    check("busy_t4", busy, 0);
    END = 1'b0;

    // 5: timeout, sticky error, cleared by next go
    tick(3);
    start_job(16'h0000, 16'd0, 16'h0020, 16'd2);
    wait_for(0, 5, "start_seen_t5");
    s0 = cyc;
    wait_for(1, TMO + 10, "done_seen_t5");
    check("error_at_done", error, 1);
    tick(1);
    check("timeout_cycle", last_done_cyc, s0 + TMO + 1);
    tick(2);
    check("error_sticky", error, 1);
    check("busy_t5", busy, 0);
    start_job(16'h0000, 16'd0, 16'h0020, 16'd0);
    check("error_cleared", error, 0);
    tick(2); END = 1'b1;
    wait_for(1, 20, "done_seen_t5b");
    END = 1'b0;
    tick(3);

    // 6: go ignored while busy, async reset in READ_HOLD
    out_ready = 1'b0;
    start_job(16'h0080, 16'd2, 16'h0020, 16'd2);
    push_word(16'h0080, 16'h00B1);
    cfg_load_base = 16'h0090; cfg_load_len = 16'd0; go = 1'b1;
    tick(1);
    go = 1'b0;
    check("go_ignored_busy", busy, 1);
    check("go_ignored_ready", in_ready, 1);
    push_word(16'h0081, 16'h00B2);
    wait_for(0, 10, "start_seen_t6");
    tick(2); END = 1'b1;
    wait_for(2, 40, "valid_seen_t6");
    check("hold_mux_t6", addr_mux_select, 2'b10);
    #3 RESET = 1'b0;
    #1;
    check("areset_ctrl", {busy, in_ready, START, done, error, out_valid, write_from_tb, addr_mux_select}, 0);
    check("areset_bus", {current_addr, mem_data, ar_in, out_data}, 0);
    tick(2);
    RESET = 1'b1; END = 1'b0; out_ready = 1'b1;
    exp_rd.delete();
    tick(2);
    check("idle_after_reset", {busy, out_valid}, 0);
    check("mem_80_kept", mem[8'h80], 16'h00B1);
    check("mem_81_kept", mem[8'h81], 16'h00B2);
    check("writes_drained", exp_wr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mm_host_sequencer.md
Name: mm_host_sequencer

Overview:
- Host-side front end for the 4-core matrix-multiply top level.
- Loads operand words from an input stream into data memory through the testbench write port (current_addr / write_from_tb / mem_data), then hands the address mux to core 1 and pulses START.
- Waits for END, then reads the result region back through the read-address path (ar_in) and streams it out.
- Replaces the hand-driven testbench sequence, so a bench or UART bridge only has to supply and drain a valid/ready stream.

Parameters:
- DATA_W, 16, data memory word width.
- ADDR_W, 16, data memory address width.
- RD_LAT, 1, cycles from ar_in change to valid dmem_rd_data (1..4).
- TIMEOUT, 65535, maximum RUN_WAIT cycles before aborting with error.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- go  in  1  start-of-job pulse; sampled only in IDLE.
- cfg_load_base  in  ADDR_W  first data-memory address to load.
- cfg_load_len  in  16  number of words to load.
- cfg_res_base  in  ADDR_W  first result address.
- cfg_res_len  in  16  number of result words to read.
- in_valid  in  1  input stream word valid.
- in_data  in  DATA_W  input stream word.
- in_ready  out  1  sequencer accepts in_data this cycle.
- current_addr  out  ADDR_W  write address to data memory.
- write_from_tb  out  1  data memory write enable (testbench port).
- mem_data  out  DATA_W  write data to data memory.
- addr_mux_select  out  2  data memory address source: 00 core, 01 write path, 10 read path.
- ar_in  out  ADDR_W  read address to data memory.
- dmem_rd_data  in  DATA_W  data memory port-1 read data.
- START  out  1  core start pulse.
- END  in  1  core completion level.
- out_valid  out  1  result word valid.
- out_data  out  DATA_W  result word.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job completion.
- error  out  1  sticky timeout flag; cleared by the next accepted go.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE. All outputs 0, including addr_mux_select=00. Internal counters 0. A reset mid-job abandons the job immediately; memory contents already written are not undone.
- IDLE:
  - go=1 latches all cfg_* values, clears error, and goes to LOAD; if cfg_load_len=0 it goes directly to RUN_PULSE.
  - go is ignored in every other state.
- LOAD:
  - addr_mux_select=01 and in_ready=1.
  - On each in_valid&&in_ready cycle: write_from_tb=1, mem_data=in_data, current_addr=load_base+k, k++. Zero bubbles between back-to-back words.
  - write_from_tb=0 on cycles without in_valid.
  - After the word with k=len-1, go to RUN_PULSE; in_ready=0 from the next cycle.
  - Address arithmetic wraps modulo 2^ADDR_W.
- RUN_PULSE: addr_mux_select=00; START=1 for exactly one cycle; then RUN_WAIT.
- RUN_WAIT:
  - addr_mux_select=00. END is registered; a rising edge of END (END=1, previous sample 0) advances the state. An END already high on entry does not count.
  - A cycle counter increments each cycle. On reaching TIMEOUT: error=1, done pulses, state returns to IDLE, and the read phase is skipped.
  - On END rising: go to READ_ISSUE, or DONE if cfg_res_len=0.
- READ_ISSUE: addr_mux_select=10, ar_in=res_base+r; wait RD_LAT cycles (READ_WAIT) holding ar_in.
- READ_WAIT end: capture dmem_rd_data into out_data; out_valid=1 (READ_HOLD).
- READ_HOLD:
  - out_valid and out_data stay stable until out_ready=1.
  - On handshake: r++; if r=len go to DONE, else go to READ_ISSUE with the next address.
  - Throughput is one word per RD_LAT+1 cycles when out_ready stays high.
- DONE: done=1 for one cycle; addr_mux_select=00; go to IDLE. busy falls the cycle after done.
- write_from_tb is never 1 outside LOAD.
- START is never 1 outside RUN_PULSE.
- out_valid is never 1 outside READ_HOLD.

Test Plan:
1. Basic job, loading: reset, then go with load_base=0, load_len=4, res_base=0x20, res_len=2. Stream 5,6,7,8 with in_valid held high → writes at addresses 0..3 on 4 consecutive cycles with mux=01; then START high for exactly 1 cycle.
2. Basic job, readback: continue test 1, raise END 10 cycles later, memory[0x20]=0x11, memory[0x21]=0x22 → out_data 0x11 then 0x22, mux=10 during reads, one done pulse, busy drops.
3. Stalls: gap in in_valid for 3 cycles mid-load, out_ready low for 5 cycles on the first result → no writes during the gap; out_data held stable at 0x11 through the stall; no words lost or duplicated.
4. Zero lengths and stale END: load_len=0, res_len=0, END already high at go → START pulses the cycle after go; sequencer waits for END to fall and rise again, then done with no reads.
5. Timeout: TIMEOUT=8 and END never rises → error=1 and done after 8 RUN_WAIT cycles, no reads; the next go clears error.
6. Async reset mid-job: RESET low during READ_HOLD → all outputs 0 immediately, state IDLE; go while busy (e.g. during LOAD) is ignored.
